// File: rtl/memristor_pkg.sv
// memristor_pkg: shared types for the memristor pulse sequencer.
// State encoding, drive-direction constants and the read-code type.
package memristor_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PULSE,
      S_GAP,
      S_VRD_REQ,
      S_VRD_WAIT,
      S_DONE
   } mctl_state_t;

   localparam logic MDIR_INC = 1'b1;
   localparam logic MDIR_DEC = 1'b0;

   typedef logic [7:0] mcode_t;

   // Counter width able to hold the longest phase length.
   function automatic int tmr_width(int pw, int gw);
      int m;
      m = (pw > gw) ? pw : gw;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/memristor_pulse_timer.sv
// memristor_pulse_timer: loadable down-counter with terminal-count flag.
// Shared by the pulse-high and dead-time phases of the sequencer.
module memristor_pulse_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/memristor_pulse_ctrl.sv
// memristor_pulse_ctrl: pulse-train sequencer for one memristor cell.
// Define MEMRISTOR_VERIFY_EN to build the read-verify trim loop.
module memristor_pulse_ctrl
   import memristor_pkg::*;
#(
   parameter int PULSE_W   = 4,
   parameter int GAP_W     = 2,
   parameter int CNT_W     = 8,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [7:0]       cmd_target,
   input  logic             abort,
   output logic             r_inc,
   output logic             r_dec,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] pulses_issued,
   output logic             rd_req,
   input  logic             rd_valid,
   input  logic [7:0]       rd_data
);

   localparam int TW = tmr_width(PULSE_W, GAP_W);

   mctl_state_t      state;
   logic             dir;
   logic [CNT_W-1:0] remain;
   logic             abort_pend;
   logic             tmr_load;
   logic [TW-1:0]    tmr_val;
   logic             tc;

`ifdef MEMRISTOR_VERIFY_EN
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   mcode_t        target;
   logic [RW-1:0] retry;
`else
   logic unused_ok;
   assign unused_ok = ^{rd_valid, rd_data, cmd_target, MAX_RETRY != 0};
   assign rd_req = 1'b0;
`endif

   memristor_pulse_timer #(
      .W (TW)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .val  (tmr_val),
      .tc   (tc)
   );

   // Abort in PULSE loads one extra dead cycle so the drop cycle
   // is followed by a complete gap.
   always_comb begin
      tmr_load = 1'b1;
      tmr_val  = TW'(PULSE_W - 1);
      unique case (state)
         S_PULSE: begin
            tmr_load = tc | abort;
            tmr_val  = abort ? TW'(GAP_W) : TW'(GAP_W - 1);
         end
         S_GAP:   tmr_load = tc;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         dir           <= MDIR_DEC;
         remain        <= '0;
         abort_pend    <= 1'b0;
         pulses_issued <= '0;
         cmd_ready     <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         r_inc         <= 1'b0;
         r_dec         <= 1'b0;
`ifdef MEMRISTOR_VERIFY_EN
         rd_req        <= 1'b0;
         target        <= '0;
         retry         <= '0;
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
`ifdef MEMRISTOR_VERIFY_EN
         rd_req <= 1'b0;
`endif
         unique case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  dir           <= cmd_dir;
                  remain        <= cmd_count;
                  abort_pend    <= 1'b0;
                  pulses_issued <= '0;
                  cmd_ready     <= 1'b0;
                  busy          <= 1'b1;
`ifdef MEMRISTOR_VERIFY_EN
                  target        <= mcode_t'(cmd_target);
                  retry         <= '0;
`endif
                  if (cmd_count != '0) begin
                     state <= S_PULSE;
                     r_inc <= (cmd_dir == MDIR_INC);
                     r_dec <= (cmd_dir == MDIR_DEC);
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end

            S_PULSE: begin
               if (tc) begin
                  remain <= remain - CNT_W'(1);
                  if (pulses_issued != '1) begin
                     pulses_issued <= pulses_issued + CNT_W'(1);
                  end
               end
               if (abort) begin
                  abort_pend <= 1'b1;
               end
               if (tc || abort) begin
                  state <= S_GAP;
                  r_inc <= 1'b0;
                  r_dec <= 1'b0;
               end
            end

            S_GAP: begin
               if (tc) begin
                  if (abort || abort_pend) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (remain != '0) begin
                     state <= S_PULSE;
                     r_inc <= (dir == MDIR_INC);
                     r_dec <= (dir == MDIR_DEC);
                  end else begin
`ifdef MEMRISTOR_VERIFY_EN
                     state  <= S_VRD_REQ;
                     rd_req <= 1'b1;
`else
                     state <= S_DONE;
                     done  <= 1'b1;
`endif
                  end
               end else if (abort) begin
                  abort_pend <= 1'b1;
               end
            end

`ifdef MEMRISTOR_VERIFY_EN
            S_VRD_REQ: begin
               if (abort) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  state <= S_VRD_WAIT;
               end
            end

            S_VRD_WAIT: begin
               if (abort) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else if (rd_valid) begin
                  if (mcode_t'(rd_data) == target) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else if (retry < RW'(MAX_RETRY)) begin
                     // Single corrective pulse toward the target code.
                     retry  <= retry + RW'(1);
                     remain <= CNT_W'(1);
                     state  <= S_PULSE;
                     if (mcode_t'(rd_data) < target) begin
                        dir   <= MDIR_INC;
                        r_inc <= 1'b1;
                        r_dec <= 1'b0;
                     end else begin
                        dir   <= MDIR_DEC;
                        r_inc <= 1'b0;
                        r_dec <= 1'b1;
                     end
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
`endif

            S_DONE: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end

            default: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               r_inc     <= 1'b0;
               r_dec     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/memristor_pulse_ctrl.md
# memristor_pulse_ctrl

Sequencer that programs one memristor cell through its `rInc`/`rDec` terminals. It accepts a programming command (direction plus pulse count) over a valid/ready handshake and emits a train of fixed-width pulses separated by dead time, guaranteeing `r_inc` and `r_dec` are never high together. It sits between the host programming logic and the memristor model. An optional compile-time read-verify loop trims the cell toward a target conductance code.

## Interface
- `PULSE_W`, default 4: cycles each pulse is held high; minimum 1.
- `GAP_W`, default 2: dead-time cycles after every pulse, both outputs low; minimum 1.
- `CNT_W`, default 8: width of the pulse-count field.
- `MAX_RETRY`, default 3: corrective pulses allowed in verify mode.

Ports, clock and reset first:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_dir` in 1: 1 = increment (`r_inc`), 0 = decrement (`r_dec`).
- `cmd_count` in CNT_W: number of pulses; 0 is a legal no-op.
- `cmd_target` in 8: target read code, used only in verify mode.
- `abort` in 1: terminate the current command.
- `r_inc` out 1: increment drive to the memristor.
- `r_dec` out 1: decrement drive to the memristor.
- `busy` out 1: a command is in progress.
- `done` out 1: one-cycle completion strobe.
- `err` out 1: one-cycle strobe, coincident with `done`, flagging an abort or a verify failure.
- `pulses_issued` out CNT_W: completed pulses for the current or last command; saturates at all-ones.
- `rd_req` out 1: one-cycle read request (verify mode).
- `rd_valid` in 1: read data valid (verify mode).
- `rd_data` in 8: read code (verify mode).

## Operation
- **Reset values:** all outputs 0 except `cmd_ready` = 1. State is IDLE and all counters are cleared.
- **States:** IDLE, PULSE, GAP, VRD_REQ, VRD_WAIT, DONE.
- **IDLE**
  - `cmd_ready` = 1 only in this state.
  - On `cmd_valid && cmd_ready`:
    - latch `cmd_dir`, `cmd_count` and `cmd_target`;
    - clear `pulses_issued`;
    - go to PULSE if the count is nonzero, otherwise go to DONE.
- **PULSE**
  - The selected output is high for exactly PULSE_W cycles.
  - On the last of those cycles, increment `pulses_issued` and go to GAP.
- **GAP**
  - Both outputs are low for GAP_W cycles.
  - Then go to PULSE if pulses remain.
  - Otherwise go to VRD_REQ (verify mode) or DONE.
- **DONE**
  - `done` = 1 for one cycle, then return to IDLE.
- **Busy:** `busy` = 1 in every state except IDLE.
- **Mutual exclusion:** `r_inc` and `r_dec` are registered outputs. They are never both 1, including around reset and abort.
- **Abort**
  - Sampled in any busy state except DONE.
  - In PULSE: outputs drop on the next cycle, then one full GAP, then DONE with `err` = 1.
  - In GAP or a verify state: go to DONE with `err` = 1 after the current gap completes, or immediately when in a verify state.
  - In IDLE: ignored.
- **Command while busy:** `cmd_valid` is held off by `cmd_ready` = 0. There is no queueing.
- **Reset mid-pulse:** outputs drop asynchronously and the command is lost.

## Timing
- Command accepted at cycle 0 with count N ≥ 1:
  - pulse k (0-based) is high for cycles 1+k(PULSE_W+GAP_W) through k(PULSE_W+GAP_W)+PULSE_W;
  - `done` is asserted at cycle N(PULSE_W+GAP_W)+1.
- Count 0: `done` at cycle 1, no pulse.
- Back-to-back commands: the next accept is at the earliest one cycle after `done`.
- `rd_valid` may arrive any number of cycles after `rd_req`; there is no timeout.

## Configuration
- Macro: `MEMRISTOR_VERIFY_EN`.
- **Defined:**
  - After the programmed train, VRD_REQ issues `rd_req` for one cycle.
  - VRD_WAIT holds until `rd_valid`.
  - If `rd_data` == target: go to DONE.
  - Otherwise, if the retry counter is below MAX_RETRY: issue one corrective pulse (PULSE then GAP) and re-verify. The corrective pulse is `r_inc` if `rd_data` < target, else `r_dec`.
  - When retries are exhausted: DONE with `err` = 1.
  - Corrective pulses count in `pulses_issued`.
- **Undefined:**
  - The verify states are not built.
  - `rd_req` is tied to 0; `rd_valid`, `rd_data` and `cmd_target` are ignored.
  - `err` is asserted only on abort.

## Structure
- **Shared package `memristor_pkg`:**
  - the state enum `mctl_state_t`;
  - the direction constants `MDIR_INC` and `MDIR_DEC`;
  - the 8-bit read-code typedef `mcode_t`.
- **One sub-module, `memristor_pulse_timer`:**
  - loadable down-counter sized for max(PULSE_W, GAP_W);
  - issues a terminal-count strobe;
  - reused for both the PULSE and GAP phases.
- The FSM, pulse and retry counters, and output registers stay in the top module.

## Test plan
All scenarios use PULSE_W=4 and GAP_W=2.
- Increment command with count 3 → `r_inc` high at cycles 1–4, 7–10 and 13–16; `r_dec` stays 0; `done` at cycle 19; `pulses_issued` = 3.
- Decrement command with count 0 → `done` at cycle 1; no pulses; `err` = 0.
- Increment command with count 5, `abort` at cycle 8 → `r_inc` low from cycle 9; `done` and `err` at cycle 12; `pulses_issued` = 1.
- Reset asserted at cycle 2 of a pulse → `r_inc` = 0 asynchronously; `cmd_ready` = 1 after release; the next command runs normally.
- With verify enabled: increment, count 2, target 10; read returns 8, then 9, then 10 → two corrective `r_inc` pulses; `done` with `err` = 0; `pulses_issued` = 4.
- With verify enabled: target 10 and reads always returning 12 → three `r_dec` corrective pulses, then `done` and `err` = 1.
